// File: rtl/tristate_bus_arbiter_pkg.sv
// Shared definitions for the tri-state bus arbiter family.
//   state_t       : arbiter FSM states
//   params_legal  : legal-range check for N_DRV / TURNAROUND / MAX_HOLD
//   rr_winner     : round-robin winner index from (req, search start pointer)
package tristate_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    TURN
  } state_t;

  localparam int unsigned MAX_DRV = 16;

  function automatic bit params_legal(input int unsigned n_drv,
                                      input int unsigned turnaround,
                                      input int unsigned max_hold);
    return (n_drv >= 2) && (n_drv <= MAX_DRV) &&
           (turnaround >= 1) && (turnaround <= 15) &&
           (max_hold >= 1) && (max_hold <= 255);
  endfunction

  // Search begins at ptr and wraps at n; the first set request bit wins.
  // Returns 0 when nothing is requesting (callers qualify with any_req).
  function automatic logic [3:0] rr_winner(input logic [15:0] req,
                                           input logic [3:0]  ptr,
                                           input int unsigned n);
    logic [3:0]  win;
    logic        found;
    int unsigned idx;
    win   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < n; k++) begin
      idx = {28'd0, ptr} + k;
      if (idx >= n) idx = idx - n;
      if (!found && req[idx[3:0]]) begin
        win   = idx[3:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/tristate_bus_arbiter_rr_pick.sv
// Combinational round-robin priority selector.
//   req     : request vector, one bit per requester
//   ptr     : index where the priority search starts
//   winner  : index of the first requester at or after ptr (wrapping)
//   any_req : high when any request bit is set
module rr_pick
  import tristate_bus_arbiter_pkg::*;
#(
  parameter  int unsigned N  = 4,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] winner,
  output logic          any_req
);

  always_comb begin
    winner  = PW'(rr_winner(16'(req), 4'(ptr), N));
    any_req = |req;
  end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Enable generator for a bank of tri-state drivers sharing one bus.
// Round-robin arbitration, bounded hold time, and an all-enables-low
// turnaround gap between owners so two drivers never overlap.
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   req        : level request per driver
//   oe         : one-hot-or-zero driver enables (registered)
//   owner      : current owner index, valid when bus_busy=1
//   bus_busy   : high when any oe bit is high
//   turnaround : high during gap cycles between owners
module tristate_bus_arbiter
  import tristate_bus_arbiter_pkg::*;
#(
  parameter int unsigned N_DRV      = 4,
  parameter int unsigned TURNAROUND = 1,
  parameter int unsigned MAX_HOLD   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_DRV-1:0]         req,
  output logic [N_DRV-1:0]         oe,
  output logic [$clog2(N_DRV)-1:0] owner,
  output logic                     bus_busy,
  output logic                     turnaround
);

  localparam int unsigned OW = $clog2(N_DRV);
  localparam int unsigned HW = $clog2(MAX_HOLD + 1);
  localparam int unsigned TW = $clog2(TURNAROUND + 1);

  if (!params_legal(N_DRV, TURNAROUND, MAX_HOLD)) begin : g_bad_params
    $error("tristate_bus_arbiter: parameter out of legal range");
  end

  state_t        state;
  logic [OW-1:0] ptr;
  logic [HW-1:0] hold_cnt;
  logic [TW-1:0] ta_cnt;

  logic [OW-1:0]    winner;
  logic             any_req;
  logic [N_DRV-1:0] win_oe;
  logic [OW-1:0]    win_ptr;

  rr_pick #(
    .N(N_DRV)
  ) u_rr_pick (
    .req     (req),
    .ptr     (ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  always_comb begin
    win_oe  = {{(N_DRV-1){1'b0}}, 1'b1} << winner;
    win_ptr = (winner == OW'(N_DRV - 1)) ? '0 : winner + OW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      oe         <= '0;
      owner      <= '0;
      bus_busy   <= 1'b0;
      turnaround <= 1'b0;
      hold_cnt   <= '0;
      ta_cnt     <= '0;
      ptr        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state    <= GRANT;
            oe       <= win_oe;
            owner    <= winner;
            bus_busy <= 1'b1;
            hold_cnt <= HW'(1);
            ptr      <= win_ptr;
          end
        end

        // hold_cnt counts cycles oe has already been high, so release
        // on reaching MAX_HOLD gives exactly MAX_HOLD enabled cycles.
        GRANT: begin
          if (!req[owner] || (hold_cnt == HW'(MAX_HOLD))) begin
            state      <= TURN;
            oe         <= '0;
            bus_busy   <= 1'b0;
            turnaround <= 1'b1;
            hold_cnt   <= '0;
            ta_cnt     <= TW'(1);
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end

        // Arbitration happens only on the final gap cycle so requests
        // raised anywhere inside the gap are still considered.
        TURN: begin
          if (ta_cnt == TW'(TURNAROUND)) begin
            turnaround <= 1'b0;
            ta_cnt     <= '0;
            if (any_req) begin
              state    <= GRANT;
              oe       <= win_oe;
              owner    <= winner;
              bus_busy <= 1'b1;
              hold_cnt <= HW'(1);
              ptr      <= win_ptr;
            end else begin
              state <= IDLE;
            end
          end else begin
            ta_cnt <= ta_cnt + TW'(1);
          end
        end

        default: begin
          state      <= IDLE;
          oe         <= '0;
          bus_busy   <= 1'b0;
          turnaround <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Self-checking bench: a cycle model of the arbitration rules checks two
// instances every cycle (TURNAROUND=1/MAX_HOLD=8 directed, TURNAROUND=2/
// MAX_HOLD=3 random), plus hand-computed literal checks.
module tb_tristate_bus_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req_a, req_b;
  logic [3:0] oe_a, oe_b;
  logic [1:0] owner_a, owner_b;
  logic       busy_a, busy_b, ta_a, ta_b;

  int errors = 0;
  int checks = 0;
  bit sweep_done = 0;

  tristate_bus_arbiter #(
    .N_DRV(4), .TURNAROUND(1), .MAX_HOLD(8)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .oe(oe_a),
    .owner(owner_a), .bus_busy(busy_a), .turnaround(ta_a)
  );

  tristate_bus_arbiter #(
    .N_DRV(4), .TURNAROUND(2), .MAX_HOLD(3)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .oe(oe_b),
    .owner(owner_b), .bus_busy(busy_b), .turnaround(ta_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: owner = -1 means bus free; gap = zero cycles still to run;
  // last = most recent owner (search starts just after it).
  typedef struct {
    int owner;
    int held;
    int gap;
    int last;
  } mstate_t;

  function automatic mstate_t mreset();
    mstate_t s;
    s.owner = -1; s.held = 0; s.gap = 0; s.last = 3;
    return s;
  endfunction

  function automatic int pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  function automatic mstate_t step(input mstate_t s, input logic [3:0] r,
                                   input int ta, input int mh);
    mstate_t n;
    int w;
    n = s;
    if (s.owner >= 0) begin
      if (!r[s.owner] || s.held == mh) begin
        n.owner = -1;
        n.gap   = ta;
      end else begin
        n.held = s.held + 1;
      end
    end else begin
      if (s.gap > 0) n.gap = s.gap - 1;
      if (n.gap == 0) begin
        w = pick(r, s.last);
        if (w >= 0) begin
          n.owner = w; n.held = 1; n.last = w;
        end
      end
    end
    return n;
  endfunction

  function automatic logic [3:0] moe(input mstate_t s);
    return (s.owner >= 0) ? (4'b0001 << s.owner) : 4'b0000;
  endfunction

  mstate_t ma, mb;
  int      zero_run;
  bit      seen;
  logic [3:0] prev_oe_b;

  always begin
    @(posedge clk);
    if (!rst_n) begin
      ma = mreset(); mb = mreset();
      zero_run = 0; seen = 0; prev_oe_b = '0;
    end else begin
      ma = step(ma, req_a, 1, 8);
      mb = step(mb, req_b, 2, 3);
    end
    #1;
    chk("a_oe", oe_a, moe(ma));
    chk("a_busy", busy_a, ma.owner >= 0);
    chk("a_turn", ta_a, ma.gap > 0);
    if (ma.owner >= 0) chk("a_owner", owner_a, ma.owner);
    chk("b_oe", oe_b, moe(mb));
    chk("b_busy", busy_b, mb.owner >= 0);
    chk("b_turn", ta_b, mb.gap > 0);
    if (mb.owner >= 0) chk("b_owner", owner_b, mb.owner);
    chk("b_onehot", $countones(oe_b) <= 1, 1);
    chk("b_busy_or", busy_b, |oe_b);
    if (oe_b != 4'b0000) begin
      if (seen && (zero_run > 0 || oe_b != prev_oe_b)) chk("b_gap", zero_run >= 2, 1);
      seen = 1;
      zero_run = 0;
    end else begin
      zero_run++;
    end
    prev_oe_b = oe_b;
  end

  initial begin
    req_b = '0;
    repeat (10000) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) req_b = 4'($urandom_range(0, 15));
    end
    sweep_done = 1;
  end

  int order [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst_n = 1'b0;
    req_a = '0;
    @(negedge clk);
    chk("rst_oe", oe_a, 4'b0000);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_turn", ta_a, 1'b0);
    chk("rst_owner", owner_a, 2'd0);

    // reset mid-grant
    rst_n = 1'b1;
    req_a = 4'b0010;
    @(negedge clk);
    chk("pre_rst_oe", oe_a, 4'b0010);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_oe", oe_a, 4'b0000);
    chk("async_rst_busy", busy_a, 1'b0);
    @(negedge clk);
    req_a = 4'b1111;
    rst_n = 1'b1;

    // fairness: 0,1,2,3,0 with 8-cycle periods and one gap cycle
    for (int p = 0; p < 5; p++) begin
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        chk("fair_oe", oe_a, 4'b0001 << order[p]);
      end
      if (p < 4) begin
        @(negedge clk);
        chk("fair_gap_oe", oe_a, 4'b0000);
        chk("fair_gap_turn", ta_a, 1'b1);
      end
    end
    req_a = 4'b0000;
    repeat (3) @(negedge clk);
    chk("idle_oe", oe_a, 4'b0000);
    chk("idle_turn", ta_a, 1'b0);

    // single requester for 3 cycles
    req_a = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("single_oe", oe_a, 4'b0100);
    end
    req_a = 4'b0000;
    @(negedge clk);
    chk("single_gap_oe", oe_a, 4'b0000);
    chk("single_gap_turn", ta_a, 1'b1);
    @(negedge clk);
    chk("single_idle_turn", ta_a, 1'b0);
    chk("single_idle_oe", oe_a, 4'b0000);

    // hold limit and re-grant of a sole requester
    req_a = 4'b0010;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("hold_oe", oe_a, 4'b0010);
    end
    @(negedge clk);
    chk("hold_gap_oe", oe_a, 4'b0000);
    chk("hold_gap_turn", ta_a, 1'b1);
    @(negedge clk);
    chk("hold_regrant_oe", oe_a, 4'b0010);
    req_a = 4'b0000;
    repeat (3) @(negedge clk);

    // late request during the gap: previous owner 2, so 3 beats 0
    req_a = 4'b0100;
    @(negedge clk);
    chk("late_own2_oe", oe_a, 4'b0100);
    @(negedge clk);
    req_a = 4'b0001;
    @(negedge clk);
    chk("late_gap_turn", ta_a, 1'b1);
    req_a = 4'b1001;
    @(negedge clk);
    chk("late_win_oe", oe_a, 4'b1000);
    chk("late_win_owner", owner_a, 2'd3);
    req_a = 4'b0000;
    repeat (3) @(negedge clk);

    while (!sweep_done) @(negedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
